// File: rtl/addsub_serial.sv
// Digit-serial adder/subtractor: a WIDTH-bit operand pair is consumed DIGIT bits per clock,
// LSB digit first, behind valid/ready handshakes, with carry, signed-overflow and zero flags.
module addsub_serial #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             m,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] S,
  output logic             ca_out,
  output logic             ovf,
  output logic             zero
);

  localparam int NDIG = WIDTH / DIGIT;
  localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;

  if (WIDTH < 2) begin : gBadWidth
    $error("addsub_serial: WIDTH must be >= 2");
  end
  if ((WIDTH % DIGIT) != 0) begin : gBadDigit
    $error("addsub_serial: WIDTH must be a multiple of DIGIT");
  end

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_opA;
  logic [WIDTH-1:0] r_opB;
  logic [WIDTH-1:0] r_res;
  logic             r_carry;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_s;
  logic             r_caOut;
  logic             r_ovf;
  logic             r_zero;
  logic             r_outValid;

  logic [DIGIT:0]   w_digSum;
  logic             w_msbCarryIn;
  logic [WIDTH-1:0] w_digExt;
  logic [WIDTH-1:0] w_resNext;
  logic             w_lastDigit;
  logic             w_accept;

  assign w_digSum = {1'b0, r_opA[DIGIT-1:0]} + {1'b0, r_opB[DIGIT-1:0]}
                  + {{DIGIT{1'b0}}, r_carry};

  // Carry into the top bit of a digit recovered from its sum bit: c = a ^ b ^ s.
  assign w_msbCarryIn = r_opA[DIGIT-1] ^ r_opB[DIGIT-1] ^ w_digSum[DIGIT-1];

  assign w_digExt    = WIDTH'(w_digSum[DIGIT-1:0]);
  assign w_resNext   = (r_res >> DIGIT) | (w_digExt << (WIDTH - DIGIT));
  assign w_lastDigit = (r_cnt == CW'(NDIG - 1));

  assign in_ready = rst_n && ((r_state == IDLE) || ((r_state == DONE) && out_ready));
  assign w_accept = in_valid && in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_opA      <= '0;
      r_opB      <= '0;
      r_res      <= '0;
      r_carry    <= 1'b0;
      r_cnt      <= '0;
      r_s        <= '0;
      r_caOut    <= 1'b0;
      r_ovf      <= 1'b0;
      r_zero     <= 1'b0;
      r_outValid <= 1'b0;
    end else if (w_accept) begin
      // Subtraction is A + ~B + 1: invert B here and seed the carry with m.
      r_opA      <= A;
      r_opB      <= m ? ~B : B;
      r_carry    <= m;
      r_cnt      <= '0;
      r_outValid <= 1'b0;
      r_state    <= RUN;
    end else begin
      unique case (r_state)
        IDLE: r_state <= IDLE;
        RUN: begin
          r_opA   <= r_opA >> DIGIT;
          r_opB   <= r_opB >> DIGIT;
          r_res   <= w_resNext;
          r_carry <= w_digSum[DIGIT];
          r_cnt   <= r_cnt + CW'(1);
          if (w_lastDigit) begin
            r_s        <= w_resNext;
            r_caOut    <= w_digSum[DIGIT];
            r_ovf      <= w_msbCarryIn ^ w_digSum[DIGIT];
            r_zero     <= (w_resNext == '0);
            r_outValid <= 1'b1;
            r_state    <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            r_outValid <= 1'b0;
            r_state    <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign out_valid = r_outValid;
  assign S         = r_s;
  assign ca_out    = r_caOut;
  assign ovf       = r_ovf;
  assign zero      = r_zero;

endmodule
